// File: rtl/hash_row_candidate_serializer.sv
// Holds one post-hash row and serializes its valid history candidates, lowest lane first,
// one match request per cycle; rows without candidates emit a single empty-row beat.
module hash_row_candidate_serializer #(
  parameter int HASH_ISSUE_WIDTH     = 16,
  parameter int ADDR_WIDTH           = 32,
  parameter int META_MATCH_LEN_WIDTH = 3,
  localparam int LANE_W              = $clog2(HASH_ISSUE_WIDTH)
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             input_valid,
  input  logic [ADDR_WIDTH-1:0]                            input_head_addr,
  input  logic [HASH_ISSUE_WIDTH-1:0]                      input_history_valid,
  input  logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]           input_history_addr,
  input  logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] input_meta_match_len,
  input  logic [HASH_ISSUE_WIDTH-1:0]                      input_meta_match_can_ext,
  input  logic [HASH_ISSUE_WIDTH*8-1:0]                    input_data,
  input  logic                                             input_delim,
  output logic                                             input_ready,
  output logic                                             output_valid,
  output logic                                             output_cand_valid,
  output logic [LANE_W-1:0]                                output_lane,
  output logic [ADDR_WIDTH-1:0]                            output_head_addr,
  output logic [ADDR_WIDTH-1:0]                            output_history_addr,
  output logic [META_MATCH_LEN_WIDTH-1:0]                  output_meta_match_len,
  output logic                                             output_meta_match_can_ext,
  output logic [HASH_ISSUE_WIDTH*8-1:0]                    output_data,
  output logic                                             output_last,
  output logic                                             output_delim,
  input  logic                                             output_ready,
  output logic [31:0]                                      perf_cand_cnt,
  output logic                                             dbg_state
);

  typedef enum logic {S_EMPTY = 1'b0, S_BUSY = 1'b1} state_e;

  state_e                          state_q, state_d;
  logic [HASH_ISSUE_WIDTH-1:0]     pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]           head_q, head_d;
  logic [ADDR_WIDTH-1:0]           hist_addr_q [HASH_ISSUE_WIDTH];
  logic [ADDR_WIDTH-1:0]           hist_addr_d [HASH_ISSUE_WIDTH];
  logic [META_MATCH_LEN_WIDTH-1:0] meta_q [HASH_ISSUE_WIDTH];
  logic [META_MATCH_LEN_WIDTH-1:0] meta_d [HASH_ISSUE_WIDTH];
  logic [HASH_ISSUE_WIDTH-1:0]     can_ext_q, can_ext_d;
  logic [HASH_ISSUE_WIDTH*8-1:0]   data_q, data_d;
  logic                            delim_q, delim_d;
  logic [31:0]                     cnt_q, cnt_d;

  logic [LANE_W-1:0] lane_sel;
  logic              pend_empty;
  logic              is_last;
  logic              fire;
  logic              accept;

  // Lowest pending lane wins: scan downward so the last hit is the lowest index.
  always_comb begin
    lane_sel = '0;
    for (int i = HASH_ISSUE_WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) lane_sel = LANE_W'(i);
    end
  end

  // Last beat when at most one candidate remains (zero covers the empty-row beat).
  assign pend_empty  = (pend_q == '0);
  assign is_last     = ((pend_q & (pend_q - 1'b1)) == '0);
  assign fire        = output_valid & output_ready;
  assign input_ready = (state_q == S_EMPTY) | (fire & is_last);
  assign accept      = input_valid & input_ready;
  assign dbg_state   = state_q;

  // Handshake: a beat transfers on output_valid & output_ready, a row on input_valid & input_ready;
  // all beat outputs come straight from held state, so they stay stable while stalled.
  always_comb begin
    output_valid              = 1'b0;
    output_cand_valid         = 1'b0;
    output_lane               = '0;
    output_head_addr          = '0;
    output_history_addr       = '0;
    output_meta_match_len     = '0;
    output_meta_match_can_ext = 1'b0;
    output_last               = 1'b0;
    output_delim              = 1'b0;
    output_data               = data_q;
    perf_cand_cnt             = cnt_q;
    if (state_q == S_BUSY) begin
      output_valid     = 1'b1;
      output_last      = is_last;
      output_delim     = delim_q & is_last;
      output_head_addr = head_q;
      if (!pend_empty) begin
        output_cand_valid         = 1'b1;
        output_lane               = lane_sel;
        output_head_addr          = head_q + ADDR_WIDTH'(lane_sel);
        output_history_addr       = hist_addr_q[lane_sel];
        output_meta_match_len     = meta_q[lane_sel];
        output_meta_match_can_ext = can_ext_q[lane_sel];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    head_d      = head_q;
    hist_addr_d = hist_addr_q;
    meta_d      = meta_q;
    can_ext_d   = can_ext_q;
    data_d      = data_q;
    delim_d     = delim_q;
    cnt_d       = cnt_q;
    if (fire) begin
      pend_d[lane_sel] = 1'b0;
      if (is_last) state_d = S_EMPTY;
      if (!pend_empty && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end
    // A new row overrides the drain to EMPTY so back-to-back rows have no bubble.
    if (accept) begin
      state_d   = S_BUSY;
      pend_d    = input_history_valid;
      head_d    = input_head_addr;
      can_ext_d = input_meta_match_can_ext;
      data_d    = input_data;
      delim_d   = input_delim;
      for (int i = 0; i < HASH_ISSUE_WIDTH; i++) begin
        hist_addr_d[i] = input_history_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        meta_d[i]      = input_meta_match_len[i*META_MATCH_LEN_WIDTH +: META_MATCH_LEN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      pend_q    <= '0;
      head_q    <= '0;
      can_ext_q <= '0;
      data_q    <= '0;
      delim_q   <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < HASH_ISSUE_WIDTH; i++) begin
        hist_addr_q[i] <= '0;
        meta_q[i]      <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      head_q      <= head_d;
      hist_addr_q <= hist_addr_d;
      meta_q      <= meta_d;
      can_ext_q   <= can_ext_d;
      data_q      <= data_d;
      delim_q     <= delim_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hash_row_candidate_serializer.sv
// Bench for hash_row_candidate_serializer: rows are expanded into expected beats by a
// per-row model and compared beat by beat as the DUT fires them.
module tb_hash_row_candidate_serializer;
  localparam int N  = 16;
  localparam int AW = 32;
  localparam int MW = 3;
  localparam int BW = 1 + 4 + AW + AW + MW + 1 + 1 + 1 + N*8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            input_valid = 1'b0;
  logic [AW-1:0]   input_head_addr = '0;
  logic [N-1:0]    input_history_valid = '0;
  logic [N*AW-1:0] input_history_addr = '0;
  logic [N*MW-1:0] input_meta_match_len = '0;
  logic [N-1:0]    input_meta_match_can_ext = '0;
  logic [N*8-1:0]  input_data = '0;
  logic            input_delim = 1'b0;
  logic            input_ready;
  logic            output_valid;
  logic            output_cand_valid;
  logic [3:0]      output_lane;
  logic [AW-1:0]   output_head_addr;
  logic [AW-1:0]   output_history_addr;
  logic [MW-1:0]   output_meta_match_len;
  logic            output_meta_match_can_ext;
  logic [N*8-1:0]  output_data;
  logic            output_last;
  logic            output_delim;
  logic            output_ready = 1'b0;
  logic [31:0]     perf_cand_cnt;
  logic            dbg_state;

  hash_row_candidate_serializer dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_head_addr(input_head_addr),
    .input_history_valid(input_history_valid), .input_history_addr(input_history_addr),
    .input_meta_match_len(input_meta_match_len), .input_meta_match_can_ext(input_meta_match_can_ext),
    .input_data(input_data), .input_delim(input_delim), .input_ready(input_ready),
    .output_valid(output_valid), .output_cand_valid(output_cand_valid), .output_lane(output_lane),
    .output_head_addr(output_head_addr), .output_history_addr(output_history_addr),
    .output_meta_match_len(output_meta_match_len), .output_meta_match_can_ext(output_meta_match_can_ext),
    .output_data(output_data), .output_last(output_last), .output_delim(output_delim),
    .output_ready(output_ready), .perf_cand_cnt(perf_cand_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [BW-1:0] exp_q[$];
  logic [AW-1:0] row_head_q[$];
  logic [N-1:0]  row_hv_q[$];
  logic          row_delim_q[$];

  int            ready_mode;   // 0: always ready, 1: toggle, 2: random
  logic          drive_busy;
  logic          stream_done;
  int            beats_seen, first_fire, last_fire;
  logic [AW-1:0] last_head;

  function automatic logic [BW-1:0] observed();
    return {output_cand_valid, output_lane, output_head_addr, output_history_addr,
            output_meta_match_len, output_meta_match_can_ext, output_last, output_delim, output_data};
  endfunction

  function automatic int popcount(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  // driver: present one row at a time, randomize payload, push the expected beats
  task automatic drive_rows();
    logic [AW-1:0] head;
    logic [N-1:0]  hv;
    logic          dl;
    int            hi, t;
    while (row_head_q.size() > 0) begin
      head = row_head_q.pop_front();
      hv   = row_hv_q.pop_front();
      dl   = row_delim_q.pop_front();
      input_head_addr     = head;
      input_history_valid = hv;
      input_delim         = dl;
      for (int i = 0; i < N; i++) begin
        input_history_addr[i*AW +: AW]   = $urandom();
        input_meta_match_len[i*MW +: MW] = MW'($urandom_range(0, 7));
        input_meta_match_can_ext[i]      = 1'($urandom_range(0, 1));
      end
      for (int w = 0; w < N/4; w++) input_data[w*32 +: 32] = $urandom();
      hi = -1;
      for (int i = 0; i < N; i++) if (hv[i]) hi = i;
      if (hv == '0) begin
        exp_q.push_back({1'b0, 4'd0, head, 32'd0, 3'd0, 1'b0, 1'b1, dl, input_data});
      end else begin
        for (int i = 0; i < N; i++) begin
          if (hv[i]) exp_q.push_back({1'b1, 4'(i), head + 32'(i), input_history_addr[i*AW +: AW],
                                      input_meta_match_len[i*MW +: MW], input_meta_match_can_ext[i],
                                      (i == hi), dl && (i == hi), input_data});
        end
      end
      input_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (input_ready) break;
        t++;
        if (t > 300) begin
          tests_run++; tests_failed++;
          $display("FAIL accept_timeout: input_ready=%0b required 1 within 300 cycles", input_ready);
          break;
        end
      end
      @(posedge clk); #1;
      input_valid = 1'b0;
    end
    drive_busy = 1'b0;
  endtask

  // collector: compare each fired beat with the scoreboard, and check stall stability
  task automatic collect();
    logic [BW-1:0] snap, obs, exp;
    logic          stalled = 1'b0;
    int            idle = 0;
    while (drive_busy || exp_q.size() > 0) begin
      @(negedge clk);
      obs = observed();
      if (stalled && output_valid) begin
        tests_run++;
        if (obs !== snap) begin
          tests_failed++;
          $display("FAIL stall_stable: got %h required %h", obs, snap);
        end
      end
      stalled = output_valid && !output_ready;
      snap    = obs;
      if (output_valid && output_ready) begin
        idle = 0;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL extra_beat: got %h required no beat", obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            tests_failed++;
            $display("FAIL beat: got %h required %h", obs, exp);
          end
        end
        if (beats_seen == 0) first_fire = cyc;
        last_fire = cyc;
        last_head = output_head_addr;
        beats_seen++;
      end else begin
        idle++;
        if (idle > 300) begin
          tests_run++; tests_failed++;
          $display("FAIL beat_timeout: %0d beats still pending, required 0", exp_q.size());
          exp_q.delete();
          break;
        end
      end
    end
  endtask

  task automatic ready_driver();
    while (!stream_done) begin
      @(posedge clk); #1;
      case (ready_mode)
        0: output_ready = 1'b1;
        1: output_ready = ~output_ready;
        default: output_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic stream(input int mode);
    ready_mode  = mode;
    beats_seen  = 0;
    drive_busy  = 1'b1;
    stream_done = 1'b0;
    output_ready = (mode != 1);
    fork
      drive_rows();
      begin collect(); stream_done = 1'b1; end
      ready_driver();
    join
    output_ready = 1'b1;
  endtask

  task automatic add_row(input logic [AW-1:0] head, input logic [N-1:0] hv, input logic dl);
    row_head_q.push_back(head);
    row_hv_q.push_back(hv);
    row_delim_q.push_back(dl);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    input_valid = 1'b0;
    output_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1 || perf_cand_cnt !== 32'd0 ||
        output_last !== 1'b0 || output_data !== '0 || output_head_addr !== '0 || dbg_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b ready=%b cnt=%0d last=%b state=%b required 0,1,0,0,0",
               output_valid, input_ready, perf_cand_cnt, output_last, dbg_state);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_row();
    input_head_addr = 32'd40;
    input_history_valid = 16'h00F0;
    input_delim = 1'b1;
    input_valid = 1'b1;
    output_ready = 1'b1;
    @(posedge clk); #1;
    input_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    tests_run++;
    if (perf_cand_cnt !== 32'd2 || output_lane !== 4'd6) begin
      tests_failed++;
      $display("FAIL mid_row_progress: cnt=%0d lane=%0d required 2 and 6", perf_cand_cnt, output_lane);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1 || perf_cand_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_row: valid=%b ready=%b cnt=%0d required 0,1,0",
               output_valid, input_ready, perf_cand_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (output_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_beat_after_reset: valid=%b required 0", output_valid);
    end
  endtask

  task automatic test_lane_order();
    logic [31:0] c0;
    c0 = perf_cand_cnt;
    add_row(32'd100, 16'h8005, 1'b0);
    stream(0);
    tests_run++;
    if (beats_seen != 3 || last_fire - first_fire != 2 || perf_cand_cnt !== c0 + 32'd3) begin
      tests_failed++;
      $display("FAIL lane_order_timing: beats=%0d span=%0d cnt=%0d required 3,2,%0d",
               beats_seen, last_fire - first_fire, perf_cand_cnt, c0 + 32'd3);
    end
  endtask

  task automatic test_empty_row();
    logic [31:0] c0;
    c0 = perf_cand_cnt;
    add_row(32'h1234, 16'h0000, 1'b1);
    add_row(32'h2000, 16'h0001, 1'b0);
    stream(0);
    tests_run++;
    if (beats_seen != 2 || last_fire - first_fire != 1 || perf_cand_cnt !== c0 + 32'd1) begin
      tests_failed++;
      $display("FAIL empty_row: beats=%0d span=%0d cnt=%0d required 2,1,%0d",
               beats_seen, last_fire - first_fire, perf_cand_cnt, c0 + 32'd1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_row(32'h500, 16'h0003, 1'b0);
    add_row(32'h600, 16'h0001, 1'b1);
    stream(0);
    tests_run++;
    if (beats_seen != 3 || last_fire - first_fire != 2 || perf_cand_cnt !== 32'd3) begin
      tests_failed++;
      $display("FAIL back_to_back: beats=%0d span=%0d cnt=%0d required 3,2,3",
               beats_seen, last_fire - first_fire, perf_cand_cnt);
    end
  endtask

  task automatic test_stall();
    add_row(32'h7000, 16'h0FFF, 1'b1);
    stream(1);
    tests_run++;
    if (beats_seen != 12) begin
      tests_failed++;
      $display("FAIL stall_beats: got %0d required 12", beats_seen);
    end
  endtask

  task automatic test_wrap();
    add_row(32'hFFFF_FFFE, 16'h0004, 1'b0);
    stream(0);
    tests_run++;
    if (last_head !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL addr_wrap: got %h required 00000000", last_head);
    end
  endtask

  task automatic test_random();
    logic [31:0] c0;
    logic [N-1:0] hv;
    int exp_cands = 0;
    c0 = perf_cand_cnt;
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: hv = '0;
        1: hv = N'(1) << $urandom_range(0, N-1);
        default: hv = N'($urandom());
      endcase
      exp_cands += popcount(hv);
      add_row($urandom(), hv, 1'($urandom_range(0, 1)));
    end
    stream(2);
    tests_run++;
    if (perf_cand_cnt !== c0 + 32'(exp_cands)) begin
      tests_failed++;
      $display("FAIL random_cnt: got %0d required %0d", perf_cand_cnt, c0 + 32'(exp_cands));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_row();
    test_lane_order();
    test_empty_row();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
